// File: rtl/adder_result_accumulator_if.sv
// Handshake and result bus between an upstream 4-bit adder and the result accumulator.
//   master : upstream side; drives start/in_valid/sum/carry and observes status/results.
//   slave  : accumulator side; drives in_ready/acc_out/count/busy/done/overflow.
interface adder_result_accumulator_if #(
  parameter int unsigned ACC_WIDTH = 8
);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           sum;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_out;
  logic [2:0]           count;
  logic                 busy;
  logic                 done;
  logic                 overflow;

  modport master (
    output start, in_valid, sum, carry,
    input  in_ready, acc_out, count, busy, done, overflow
  );

  modport slave (
    input  start, in_valid, sum, carry,
    output in_ready, acc_out, count, busy, done, overflow
  );
endinterface

// File: rtl/adder_result_accumulator.sv
// Accumulates a frame of MAX_COUNT results from an upstream 4-bit adder.
// Each accepted operand is {carry, sum} (0..30), added modulo 2^ACC_WIDTH; overflow is sticky
// for the frame. A frame begins on start in idle and ends with a one-cycle done pulse.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - adder_result_accumulator_if.slave: start, in_valid, sum, carry in;
//          in_ready, acc_out, count, busy, done, overflow out
module adder_result_accumulator #(
  parameter int unsigned ACC_WIDTH = 8,
  parameter int unsigned MAX_COUNT = 4
) (
  input logic                       clk,
  input logic                       rst,
  adder_result_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  localparam logic [2:0] MaxCount = 3'(MAX_COUNT);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [2:0]           count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic                 xfer;
  logic [ACC_WIDTH:0]   operand;
  logic [ACC_WIDTH:0]   sum_full;

  // One extra bit on the adder exposes the carry-out used for overflow detection.
  assign operand  = {{(ACC_WIDTH - 4){1'b0}}, bus.carry, bus.sum};
  assign sum_full = {1'b0, acc_q} + operand;
  assign xfer     = (state_q == StAccum) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StAccum;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      StAccum: begin
        if (xfer) begin
          acc_d   = sum_full[ACC_WIDTH-1:0];
          count_d = count_q + 3'd1;
          if (sum_full[ACC_WIDTH]) begin
            ovf_d = 1'b1;
          end
          if (count_q + 3'd1 == MaxCount) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status outputs decode straight from the state register, so reset clears them at once.
  assign bus.in_ready = (state_q == StAccum);
  assign bus.busy     = (state_q == StAccum);
  assign bus.done     = (state_q == StDone);
  assign bus.acc_out  = acc_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule
